// File: rtl/adma_descriptor_writer_if.sv
// Descriptor handshake and RAM write bus of the ADMA descriptor writer.
// The master modport is the writer; the slave modport is the descriptor source plus RAM.
interface adma_descriptor_writer_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [95:0] descriptor;
  logic [63:0] ram_address;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_ack;

  modport master (
    input  desc_valid,
    input  descriptor,
    input  ram_ack,
    output desc_ready,
    output ram_address,
    output ram_wdata,
    output ram_we
  );

  modport slave (
    output desc_valid,
    output descriptor,
    output ram_ack,
    input  desc_ready,
    input  ram_address,
    input  ram_wdata,
    input  ram_we
  );
endinterface

// File: rtl/adma_descriptor_writer.sv
// Writes 96-bit ADMA descriptors to RAM as three consecutive 32-bit words and
// maintains the descriptor-table write pointer, descriptor count and timeout flag.
module adma_descriptor_writer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                     CLK,
  input  logic                     RESET,
  adma_descriptor_writer_if.master bus,
  input  logic [63:0]              table_base,
  input  logic                     table_restart,
  output logic [63:0]              table_pointer,
  output logic [15:0]              desc_count,
  output logic                     write_done,
  output logic                     error
);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    WR_W0 = 6'b000010,
    WR_W1 = 6'b000100,
    WR_W2 = 6'b001000,
    DONE  = 6'b010000,
    ERR   = 6'b100000
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [95:0]     desc_q;
  logic [TO_W-1:0] to_count;
  logic            in_write;
  logic            timeout_hit;
  logic            accept;

  assign in_write    = (state == WR_W0) || (state == WR_W1) || (state == WR_W2);
  assign timeout_hit = in_write && !bus.ram_ack && (to_count == TO_LAST);
  assign accept      = (state == IDLE) && !table_restart && bus.desc_valid;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Bus outputs are decoded from state and registered pointer/descriptor; reset forces them quiet at once
  always_comb begin
    state_next      = state;
    bus.desc_ready  = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_address = '0;
    bus.ram_wdata   = '0;
    write_done      = 1'b0;
    case (state)
      IDLE: begin
        bus.desc_ready = !table_restart;
        if (accept) state_next = WR_W0;
      end
      WR_W0: begin
        bus.ram_we      = 1'b1;
        bus.ram_address = table_pointer;
        bus.ram_wdata   = desc_q[31:0];
        if (bus.ram_ack)  state_next = WR_W1;
        else if (timeout_hit) state_next = ERR;
      end
      WR_W1: begin
        bus.ram_we      = 1'b1;
        bus.ram_address = table_pointer + 64'd4;
        bus.ram_wdata   = desc_q[63:32];
        if (bus.ram_ack)  state_next = WR_W2;
        else if (timeout_hit) state_next = ERR;
      end
      WR_W2: begin
        bus.ram_we      = 1'b1;
        bus.ram_address = table_pointer + 64'd8;
        bus.ram_wdata   = desc_q[95:64];
        if (bus.ram_ack)  state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE: begin
        write_done = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        if (table_restart) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (RESET) begin
      state_next      = IDLE;
      bus.desc_ready  = 1'b0;
      bus.ram_we      = 1'b0;
      bus.ram_address = '0;
      bus.ram_wdata   = '0;
      write_done      = 1'b0;
    end
  end

  // Pointer and count move on the last acked word so they already show the new value in DONE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      table_pointer <= '0;
      desc_count    <= '0;
      error         <= 1'b0;
      desc_q        <= '0;
      to_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_count <= '0;
          if (table_restart) begin
            table_pointer <= table_base;
            desc_count    <= '0;
            error         <= 1'b0;
          end else if (bus.desc_valid) begin
            desc_q <= bus.descriptor;
          end
        end
        WR_W0, WR_W1, WR_W2: begin
          if (bus.ram_ack) begin
            to_count <= '0;
          end else if (timeout_hit) begin
            to_count <= '0;
            error    <= 1'b1;
          end else begin
            to_count <= to_count + 1'b1;
          end
          if ((state == WR_W2) && bus.ram_ack) begin
            table_pointer <= desc_q[1] ? table_base : (table_pointer + 64'd12);
            desc_count    <= desc_count + 16'd1;
          end
        end
        ERR: begin
          if (table_restart) begin
            table_pointer <= table_base;
            desc_count    <= '0;
            error         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adma_descriptor_writer.sv
// Self-checking bench for adma_descriptor_writer: a RAM responder compares every
// write against a scoreboard filled by a reference model of the table pointer.
module tb_adma_descriptor_writer;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] table_base;
  logic        table_restart;
  logic [63:0] table_pointer;
  logic [15:0] desc_count;
  logic        write_done;
  logic        error;

  adma_descriptor_writer_if bus ();

  adma_descriptor_writer #(.TIMEOUT(16), .TO_W(5)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .bus           (bus.master),
    .table_base    (table_base),
    .table_restart (table_restart),
    .table_pointer (table_pointer),
    .desc_count    (desc_count),
    .write_done    (write_done),
    .error         (error)
  );

  always #5 CLK = ~CLK;

  int          errCount   = 0;
  int          checkCount = 0;
  wr_t         expQ[$];
  logic [63:0] modelBase  = '0;
  logic [63:0] modelPtr   = '0;
  logic [15:0] modelCount = '0;
  int          stallWord  = -1;
  int          stallLen   = 0;
  bit          ackNever   = 1'b0;
  int          wordIdx    = 0;
  int          waitCnt    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // RAM model: checks each presented word against the scoreboard head and acks per the stall setup
  always @(negedge CLK) begin
    bus.ram_ack = 1'b0;
    if (bus.ram_we && !RESET) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 64'(bus.ram_address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        checkOutput($sformatf("w%0d_addr", wordIdx), bus.ram_address, expQ[0].addr);
        checkOutput($sformatf("w%0d_data", wordIdx), 64'(bus.ram_wdata), 64'(expQ[0].data));
        if (!ackNever) begin
          if (wordIdx == stallWord && waitCnt < stallLen) begin
            waitCnt++;
          end else begin
            bus.ram_ack = 1'b1;
            waitCnt     = 0;
            wordIdx     = (wordIdx + 1) % 3;
            void'(expQ.pop_front());
          end
        end
      end
    end else begin
      wordIdx = 0;
      waitCnt = 0;
    end
  end

  task automatic pushExpected(input logic [95:0] d);
    expQ.push_back('{addr: modelPtr,          data: d[31:0]});
    expQ.push_back('{addr: modelPtr + 64'd4,  data: d[63:32]});
    expQ.push_back('{addr: modelPtr + 64'd8,  data: d[95:64]});
    modelPtr   = d[1] ? modelBase : modelPtr + 64'd12;
    modelCount = modelCount + 16'd1;
  endtask

  // Presents one descriptor for a single accepting cycle; returns at cycle 1 after acceptance
  task automatic applyStimulus(input logic [95:0] d);
    int guard = 0;
    while (!bus.desc_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("ready_before_send", 64'(bus.desc_ready), 64'(1));
    bus.desc_valid = 1'b1;
    bus.descriptor = d;
    pushExpected(d);
    @(negedge CLK);
    bus.desc_valid = 1'b0;
  endtask

  task automatic waitDone(input int expK);
    int k    = 1;
    bit seen = 1'b0;
    while (k <= 40 && !seen) begin
      if (write_done) begin
        seen = 1'b1;
        checkOutput("done_cycle", 64'(k), 64'(expK));
        checkOutput("done_ptr", table_pointer, modelPtr);
        checkOutput("done_count", 64'(desc_count), 64'(modelCount));
        checkOutput("done_error", 64'(error), 64'(0));
        checkOutput("sb_empty", 64'(expQ.size()), 64'(0));
      end else begin
        @(negedge CLK);
        k++;
      end
    end
    if (!seen) checkOutput("done_timeout", 64'(0), 64'(1));
    @(negedge CLK);
    checkOutput("done_pulse", 64'(write_done), 64'(0));
    checkOutput("ready_after", 64'(bus.desc_ready), 64'(1));
  endtask

  task automatic restartTable(input logic [63:0] b);
    table_base    = b;
    table_restart = 1'b1;
    #1;
    checkOutput("restart_blocks_ready", 64'(bus.desc_ready), 64'(0));
    @(negedge CLK);
    table_restart = 1'b0;
    #1;
    checkOutput("restart_ptr", table_pointer, b);
    checkOutput("restart_count", 64'(desc_count), 64'(0));
    checkOutput("restart_error", 64'(error), 64'(0));
    checkOutput("restart_ready", 64'(bus.desc_ready), 64'(1));
    modelBase  = b;
    modelPtr   = b;
    modelCount = '0;
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int weCycles;
    RESET          = 1'b1;
    table_restart  = 1'b0;
    table_base     = '0;
    bus.desc_valid = 1'b0;
    bus.descriptor = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_ready", 64'(bus.desc_ready), 64'(0));
    checkOutput("rst_we", 64'(bus.ram_we), 64'(0));
    checkOutput("rst_addr", bus.ram_address, 64'(0));
    checkOutput("rst_wdata", 64'(bus.ram_wdata), 64'(0));
    checkOutput("rst_ptr", table_pointer, 64'(0));
    checkOutput("rst_count", 64'(desc_count), 64'(0));
    checkOutput("rst_done", 64'(write_done), 64'(0));
    checkOutput("rst_error", 64'(error), 64'(0));
    RESET = 1'b0;
    @(negedge CLK);

    $display("[TB] basic write");
    restartTable(64'h1000);
    applyStimulus(96'h00000003_0000ABCD_00100021);
    waitDone(4);

    $display("[TB] end descriptor wraps pointer");
    applyStimulus(96'h00000000_CAFEF00D_00000003);
    waitDone(4);

    $display("[TB] wait states on word1");
    stallWord = 1;
    stallLen  = 3;
    applyStimulus(96'h11112222_33334444_55556660);
    waitDone(7);
    stallWord = -1;

    $display("[TB] ack timeout");
    ackNever = 1'b1;
    applyStimulus(96'hDEADBEEF_01234567_89ABCDE1);
    weCycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.ram_we) break;
      weCycles++;
      @(negedge CLK);
    end
    checkOutput("timeout_we_cycles", 64'(weCycles), 64'(16));
    checkOutput("timeout_error", 64'(error), 64'(1));
    checkOutput("timeout_we_off", 64'(bus.ram_we), 64'(0));
    checkOutput("timeout_ready", 64'(bus.desc_ready), 64'(0));
    repeat (3) @(negedge CLK);
    checkOutput("err_sticky", 64'(error), 64'(1));
    checkOutput("err_ready_low", 64'(bus.desc_ready), 64'(0));
    checkOutput("err_we_low", 64'(bus.ram_we), 64'(0));
    ackNever = 1'b0;
    restartTable(64'h1000);
    applyStimulus(96'h0F0F0F0F_F0F0F0F0_12345678);
    waitDone(4);

    $display("[TB] restart and valid together");
    table_base     = 64'h2000;
    table_restart  = 1'b1;
    bus.desc_valid = 1'b1;
    bus.descriptor = 96'hA5A5A5A5_5A5A5A5A_00000001;
    #1;
    checkOutput("sim_ready_low", 64'(bus.desc_ready), 64'(0));
    @(negedge CLK);
    table_restart = 1'b0;
    #1;
    checkOutput("sim_ptr", table_pointer, 64'h2000);
    checkOutput("sim_not_accepted", 64'(bus.ram_we), 64'(0));
    checkOutput("sim_ready_high", 64'(bus.desc_ready), 64'(1));
    modelBase  = 64'h2000;
    modelPtr   = 64'h2000;
    modelCount = '0;
    pushExpected(bus.descriptor);
    @(negedge CLK);
    bus.desc_valid = 1'b0;
    waitDone(4);

    $display("[TB] reset during word1");
    applyStimulus(96'h77777777_66666666_55555554);
    @(negedge CLK);
    checkOutput("mid_we", 64'(bus.ram_we), 64'(1));
    checkOutput("mid_addr", bus.ram_address, 64'h2010);
    RESET = 1'b1;
    expQ.delete();
    @(negedge CLK);
    checkOutput("rstmid_we", 64'(bus.ram_we), 64'(0));
    checkOutput("rstmid_ptr", table_pointer, 64'(0));
    checkOutput("rstmid_count", 64'(desc_count), 64'(0));
    checkOutput("rstmid_error", 64'(error), 64'(0));
    checkOutput("rstmid_done", 64'(write_done), 64'(0));
    RESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checkOutput("post_rst_done", 64'(write_done), 64'(0));
      checkOutput("post_rst_we", 64'(bus.ram_we), 64'(0));
    end
    checkOutput("post_rst_count", 64'(desc_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adma_descriptor_writer.md
Name: adma_descriptor_writer

Overview:
- Serializes 96-bit ADMA descriptors into three 32-bit system-RAM writes at consecutive word addresses. It is the write-side counterpart of the ADMA descriptor fetch path.
- Word order matches the fetch order: word0 = desc[31:0] at ptr, word1 = desc[63:32] at ptr+4, word2 = desc[95:64] at ptr+8.
- Maintains a descriptor-table write pointer. The pointer advances 12 bytes per descriptor and returns to the table base after an End descriptor.
- Used to build descriptor tables in RAM for the ADMA engine and for test benches.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for ram_ack on one word before flagging an error.
- TO_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- desc_valid  input  1  descriptor presented on descriptor.
- desc_ready  output  1  writer can accept a descriptor this cycle.
- descriptor  input  96  descriptor to write; bit0 = Valid, bit1 = End.
- table_base  input  64  descriptor table start address.
- table_restart  input  1  load table_pointer from table_base, clear count and error.
- ram_address  output  64  write address.
- ram_wdata  output  32  write data.
- ram_we  output  1  write request; held until ram_ack.
- ram_ack  input  1  RAM accepted the current word this cycle.
- table_pointer  output  64  address the next descriptor will be written to.
- desc_count  output  16  descriptors fully written since restart.
- write_done  output  1  one-cycle pulse: descriptor fully written.
- error  output  1  sticky ack-timeout flag.

Behaviour:
- Reset values:
  - state IDLE, desc_ready=0 during reset, ram_we=0, ram_address=0, ram_wdata=0.
  - table_pointer=0, desc_count=0, write_done=0, error=0.
  - Internal descriptor register cleared.
- Reset mid-operation aborts the write immediately. No further ram_we; the partially written descriptor is not counted.
- States: IDLE, WR_W0, WR_W1, WR_W2, DONE, ERR. One-hot encoding.
- IDLE:
  - desc_ready = !table_restart.
  - table_restart=1: table_pointer<=table_base, desc_count<=0, no accept. Restart wins over a simultaneous desc_valid.
  - desc_valid & desc_ready: latch descriptor; next state WR_W0.
- WR_Wn (n=0..2):
  - ram_we=1, ram_address=table_pointer+4n, ram_wdata=latched word n, desc_ready=0.
  - ram_ack=1: advance to the next word, or to DONE after WR_W2; timeout counter cleared.
  - ram_ack=0: counter increments. When the counter reaches TIMEOUT-1 with no ack, go to ERR and set error=1.
  - ram_ack is sampled only while ram_we=1.
- Transition WR_W2->DONE updates bookkeeping:
  - If latched bit1 (End)=1: table_pointer<=table_base. Otherwise table_pointer<=table_pointer+12, wrapping modulo 2^64.
  - desc_count<=desc_count+1, wrapping at 16 bits.
  - Descriptor contents are written verbatim; the Valid bit is not checked.
- DONE: write_done=1 for exactly one cycle, then IDLE. table_pointer already shows the new value during DONE.
- ERR:
  - ram_we=0, desc_ready=0, error held at 1.
  - table_restart=1 clears error, reloads the pointer, clears the count, and returns to IDLE. Only table_restart or RESET leave ERR.
- table_restart in WR_W*/DONE is ignored.
- Latency with ack in every cycle:
  - accept at cycle 0;
  - writes in cycles 1, 2, 3;
  - write_done in cycle 4;
  - desc_ready again in cycle 5.
- Throughput: one descriptor per 5 cycles.
- Outputs during WR_W* are decoded combinationally from state plus registered pointer and descriptor.

Test Plan:
- Basic write:
  - Stimulus: restart with base=0x1000; send desc=0x00000003_0000ABCD_00100021 (End=0), ack every cycle.
  - Required: writes (0x1000, 0x00100021), (0x1004, 0x0000ABCD), (0x1008, 0x00000003); write_done in cycle 4; table_pointer=0x100C; desc_count=1.
- End wrap:
  - Stimulus: from pointer 0x100C, send a descriptor with bit1=1.
  - Required: writes at 0x100C/0x1010/0x1014; table_pointer=0x1000 after DONE; desc_count=2.
- Wait states:
  - Stimulus: ram_ack delayed 3 cycles on word1.
  - Required: ram_we and address 0x1004 held stable for 4 cycles; no error; write_done in cycle 7.
- Timeout:
  - Stimulus: ram_ack held 0 on word0.
  - Required: after 16 cycles, error=1 and ram_we=0; desc_ready stays 0.
  - Stimulus: table_restart=1.
  - Required: error=0, desc_ready=1 next cycle.
- Simultaneous restart and valid in IDLE:
  - Required: descriptor not accepted; pointer=table_base.
  - Required: desc_valid held into the next cycle is accepted.
- Reset mid-write:
  - Stimulus: assert RESET during WR_W1.
  - Required: next cycle ram_we=0, table_pointer=0, desc_count=0, error=0, no write_done.
